// File: rtl/ksm_term_writer_pkg.sv
// ksm_term_writer_pkg
// Shared constants for the terminal writer: screen geometry defaults,
// terminal control codes, FSM state encodings and a bus address helper.
package ksm_term_writer_pkg;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 25;

    localparam logic [7:0] CODE_CR = 8'h0D;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_FF = 8'h0C;

    // Default-geometry landmarks (row 1 col 0, and start of the last row)
    localparam logic [12:0] TEXT_FIRST    = 13'd80;
    localparam logic [12:0] TEXT_LAST_ROW = 13'd1920;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_CHAR = 3'd1;
    localparam logic [2:0] ST_SCR_RD  = 3'd2;
    localparam logic [2:0] ST_SCR_WR  = 3'd3;
    localparam logic [2:0] ST_CLR     = 3'd4;

    // Word-aligned bus address of a character position, wrapping mod 2^16
    function automatic logic [15:0] bus_word_adr(input logic [15:0] base,
                                                 input logic [12:0] pos);
        return base + {3'b000, pos[12:1], 1'b0};
    endfunction

endpackage

// File: rtl/ksm_term_writer_wbm.sv
// ksm_wbm_port
// Single-transaction classic Wishbone initiator. A request seen while the
// bus is idle is latched and presented (cyc=stb=1) from the next edge; the
// cycle ends on the edge where ack is sampled high. done_o/rdata_o are valid
// in the cycle ack is high, so the caller can act on the ack edge itself.
// Ports:
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   req_i/we_i/adr_i/dat_i/sel_i transaction request (held until done_o)
//   done_o, rdata_o             completion strobe and read data
//   wbm_*                       Wishbone initiator signals
module ksm_wbm_port (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] adr_i,
    input  logic [15:0] dat_i,
    input  logic [1:0]  sel_i,
    output logic        done_o,
    output logic [15:0] rdata_o,
    output logic [15:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [1:0]  wbm_sel_o,
    input  logic        wbm_ack_i
);

    logic        cyc_q;
    logic        we_q;
    logic [15:0] adr_q;
    logic [15:0] dat_q;
    logic [1:0]  sel_q;

    // The cycle after an ack always has cyc low, which gives the mandatory
    // one-cycle gap even if req_i stays asserted.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= 16'h0000;
            dat_q <= 16'h0000;
            sel_q <= 2'b00;
        end else if (cyc_q) begin
            if (wbm_ack_i) begin
                cyc_q <= 1'b0;
            end
        end else if (req_i) begin
            cyc_q <= 1'b1;
            we_q  <= we_i;
            adr_q <= adr_i;
            dat_q <= dat_i;
            sel_q <= sel_i;
        end
    end

    assign done_o    = cyc_q & wbm_ack_i;
    assign rdata_o   = wbm_dat_i;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;

endmodule

// File: rtl/ksm_term_writer.sv
// ksm_term_writer
// Turns a stream of terminal characters into writes to text video memory
// and owns the cursor. Handles CR/LF/BS/FF, line wrap, and scrolling of the
// text area (rows 1..ROWS-1) by copying it up one row with bus read/write
// pairs. Row 0 (service line) is never read or written.
// Ports:
//   wb_clk_i, wb_rst_i           clock, async active-high reset
//   char_i/char_valid_i/char_ready_o  character input handshake
//   wbm_*                        Wishbone initiator to the video adapter
//   cursor_o                     current cursor character position
//   busy_o                       operation in progress (not accepting)
module ksm_term_writer
    import ksm_term_writer_pkg::*;
#(
    parameter logic [15:0] BASE_ADR = 16'h0000,
    parameter int          COLS     = DEF_COLS,
    parameter int          ROWS     = DEF_ROWS,
    parameter logic [7:0]  FILL     = 8'h20
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  char_i,
    input  logic        char_valid_i,
    output logic        char_ready_o,
    output logic [15:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [1:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    output logic [12:0] cursor_o,
    output logic        busy_o
);

    localparam logic [12:0] FIRST_POS = 13'(COLS);
    localparam logic [12:0] LAST_ROW  = 13'(COLS * (ROWS - 1));
    localparam logic [12:0] LAST_WORD = 13'(COLS * ROWS - 2);
    localparam logic [12:0] SCR_SRC0  = 13'(2 * COLS);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);

    logic [2:0]  state_q, state_d;
    logic [12:0] cursor_q, cursor_d;
    logic [6:0]  col_q, col_d;
    logic [12:0] ptr_q, ptr_d;
    logic        scroll_q, scroll_d;
    logic [7:0]  char_q, char_d;
    logic [15:0] rdata_q, rdata_d;

    logic        req;
    logic        req_we;
    logic [12:0] req_pos;
    logic [15:0] req_dat;
    logic [1:0]  req_sel;
    logic        done;
    logic [15:0] rdata;

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        col_d    = col_q;
        ptr_d    = ptr_q;
        scroll_d = scroll_q;
        char_d   = char_q;
        rdata_d  = rdata_q;
        req      = 1'b0;
        req_we   = 1'b1;
        req_pos  = ptr_q;
        req_dat  = {FILL, FILL};
        req_sel  = 2'b11;

        case (state_q)
            ST_IDLE: begin
                if (char_valid_i) begin
                    char_d = char_i;
                    case (char_i)
                        CODE_CR: begin
                            cursor_d = cursor_q - {6'b0, col_q};
                            col_d    = 7'd0;
                        end
                        CODE_LF: begin
                            if (cursor_q >= LAST_ROW) begin
                                state_d  = ST_SCR_RD;
                                ptr_d    = SCR_SRC0;
                                scroll_d = 1'b1;
                            end else begin
                                cursor_d = cursor_q + FIRST_POS;
                            end
                        end
                        CODE_BS: begin
                            if (col_q != 7'd0) begin
                                cursor_d = cursor_q - 13'd1;
                                col_d    = col_q - 7'd1;
                            end
                        end
                        CODE_FF: begin
                            state_d  = ST_CLR;
                            ptr_d    = FIRST_POS;
                            scroll_d = 1'b0;
                            col_d    = 7'd0;
                        end
                        default: state_d = ST_WR_CHAR;
                    endcase
                end
            end
            ST_WR_CHAR: begin
                req     = 1'b1;
                req_pos = cursor_q;
                req_dat = {char_q, char_q};
                req_sel = cursor_q[0] ? 2'b10 : 2'b01;
                if (done) begin
                    state_d = ST_IDLE;
                    if (col_q == LAST_COL) begin
                        col_d = 7'd0;
                        // Wrap off the last row: cursor stays put until the
                        // scroll finishes, then lands on the last row col 0.
                        if (cursor_q >= LAST_ROW) begin
                            state_d  = ST_SCR_RD;
                            ptr_d    = SCR_SRC0;
                            scroll_d = 1'b1;
                        end else begin
                            cursor_d = cursor_q + 13'd1;
                        end
                    end else begin
                        cursor_d = cursor_q + 13'd1;
                        col_d    = col_q + 7'd1;
                    end
                end
            end
            ST_SCR_RD: begin
                req    = 1'b1;
                req_we = 1'b0;
                if (done) begin
                    rdata_d = rdata;
                    state_d = ST_SCR_WR;
                end
            end
            ST_SCR_WR: begin
                req     = 1'b1;
                req_pos = ptr_q - FIRST_POS;
                req_dat = rdata_q;
                if (done) begin
                    if (ptr_q == LAST_WORD) begin
                        state_d = ST_CLR;
                        ptr_d   = LAST_ROW;
                    end else begin
                        state_d = ST_SCR_RD;
                        ptr_d   = ptr_q + 13'd2;
                    end
                end
            end
            ST_CLR: begin
                req = 1'b1;
                if (done) begin
                    if (ptr_q == LAST_WORD) begin
                        state_d  = ST_IDLE;
                        cursor_d = scroll_q ? (LAST_ROW + {6'b0, col_q}) : FIRST_POS;
                    end else begin
                        ptr_d = ptr_q + 13'd2;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            cursor_q <= FIRST_POS;
            col_q    <= 7'd0;
            ptr_q    <= 13'd0;
            scroll_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            col_q    <= col_d;
            ptr_q    <= ptr_d;
            scroll_q <= scroll_d;
        end
    end

    // Pure data holding registers; always qualified by state before use
    always_ff @(posedge wb_clk_i) begin
        char_q  <= char_d;
        rdata_q <= rdata_d;
    end

    ksm_wbm_port u_port (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .req_i     (req),
        .we_i      (req_we),
        .adr_i     (bus_word_adr(BASE_ADR, req_pos)),
        .dat_i     (req_dat),
        .sel_i     (req_sel),
        .done_o    (done),
        .rdata_o   (rdata),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_ack_i (wbm_ack_i)
    );

    assign cursor_o     = cursor_q;
    assign char_ready_o = (state_q == ST_IDLE);
    assign busy_o       = ~char_ready_o;

endmodule

// File: tb/tb_ksm_term_writer.sv
module tb_ksm_term_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  char_i = 8'h00;
    logic        char_valid = 1'b0;
    logic        ready;
    logic [15:0] adr;
    logic [15:0] dat_o;
    logic [15:0] s_rdat = 16'h0000;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [1:0]  sel;
    logic        s_ack = 1'b0;
    logic [12:0] cursor;
    logic        busy;

    always #5 clk = ~clk;

    ksm_term_writer dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .char_i       (char_i),
        .char_valid_i (char_valid),
        .char_ready_o (ready),
        .wbm_adr_o    (adr),
        .wbm_dat_o    (dat_o),
        .wbm_dat_i    (s_rdat),
        .wbm_cyc_o    (cyc),
        .wbm_stb_o    (stb),
        .wbm_we_o     (we),
        .wbm_sel_o    (sel),
        .wbm_ack_i    (s_ack),
        .cursor_o     (cursor),
        .busy_o       (busy)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic        chk_dat;
    } txn_t;

    txn_t       exp_q[$];
    logic [7:0] mem[0:2047];
    logic [7:0] exp_mem[0:2047];
    logic       mem_load = 1'b0;
    int         wait_cnt = 0;
    int         checks = 0;
    int         errors = 0;
    int         exp_cur = 80;
    bit         mon_en = 1'b0;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 13 + 7) & 255);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Slave: 2 KB byte memory, 0-3 random wait states, registered ack
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
        end else if (!(cyc && stb)) begin
            s_ack <= 1'b0;
        end else if (s_ack) begin
            s_ack    <= 1'b0;
            wait_cnt <= int'($urandom_range(3, 0));
        end else if (wait_cnt > 0) begin
            wait_cnt <= wait_cnt - 1;
        end else begin
            s_ack  <= 1'b1;
            s_rdat <= {mem[{adr[10:1], 1'b1}], mem[{adr[10:1], 1'b0}]};
            if (we && sel[0]) mem[{adr[10:1], 1'b0}] <= dat_o[7:0];
            if (we && sel[1]) mem[{adr[10:1], 1'b1}] <= dat_o[15:8];
        end
    end

    // Monitor: each acked transfer is compared against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && cyc && stb && s_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: got we=%0b adr=%h dat=%h sel=%b expected no transfer",
                             we, adr, dat_o, sel);
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    if (we !== t.we || adr !== t.adr || sel !== t.sel ||
                        (t.chk_dat && dat_o !== t.dat)) begin
                        errors++;
                        $display("FAIL bus_txn: got we=%0b adr=%h dat=%h sel=%b expected we=%0b adr=%h dat=%h sel=%b",
                                 we, adr, dat_o, sel, t.we, t.adr, t.dat, t.sel);
                    end
                end
            end
        end
    end

    task automatic push(input logic w, input int a, input logic [15:0] d,
                        input logic [1:0] s, input logic cd);
        txn_t t;
        t.we = w; t.adr = 16'(a); t.dat = d; t.sel = s; t.chk_dat = cd;
        exp_q.push_back(t);
    endtask

    task automatic push_scroll();
        for (int s = 160; s < 2000; s += 2) begin
            push(1'b0, s, 16'h0000, 2'b11, 1'b0);
            push(1'b1, s - 80, {exp_mem[s + 1], exp_mem[s]}, 2'b11, 1'b1);
            exp_mem[s - 80] = exp_mem[s];
            exp_mem[s - 79] = exp_mem[s + 1];
        end
        for (int a = 1920; a < 2000; a += 2) begin
            push(1'b1, a, 16'h2020, 2'b11, 1'b1);
            exp_mem[a] = 8'h20; exp_mem[a + 1] = 8'h20;
        end
    endtask

    task automatic expect_code(input logic [7:0] c);
        int col;
        col = exp_cur % 80;
        case (c)
            8'h0D: exp_cur = exp_cur - col;
            8'h0A: begin
                if (exp_cur >= 1920) begin push_scroll(); exp_cur = 1920 + col; end
                else exp_cur = exp_cur + 80;
            end
            8'h08: if (col != 0) exp_cur = exp_cur - 1;
            8'h0C: begin
                for (int a = 80; a < 2000; a += 2) begin
                    push(1'b1, a, 16'h2020, 2'b11, 1'b1);
                    exp_mem[a] = 8'h20; exp_mem[a + 1] = 8'h20;
                end
                exp_cur = 80;
            end
            default: begin
                push(1'b1, exp_cur & 16'hFFFE, {c, c}, (exp_cur % 2 == 1) ? 2'b10 : 2'b01, 1'b1);
                exp_mem[exp_cur] = c;
                if (col == 79 && exp_cur >= 1920) begin push_scroll(); exp_cur = 1920; end
                else exp_cur = exp_cur + 1;
            end
        endcase
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 30000) begin @(negedge clk); n++; end
        if (!ready) check("accept_timeout", 0, 1);
        char_i = c;
        char_valid = 1'b1;
        @(posedge clk);
        #1 char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 30000) begin @(negedge clk); n++; end
        check("idle_reached", int'(ready), 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic do_code(input logic [7:0] c);
        expect_code(c);
        send(c);
        wait_idle();
        check("cursor_model", int'(cursor), exp_cur);
    endtask

    task automatic cmp_region(input string name, input int lo, input int hi);
        int bad = 0;
        for (int i = lo; i < hi; i++) if (mem[i] !== exp_mem[i]) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        int seen;
        int n;
        for (int i = 0; i < 2048; i++) exp_mem[i] = pat(i);
        #1 rst = 1'b1;
        @(negedge clk) mem_load = 1'b1;
        @(negedge clk) mem_load = 1'b0;
        @(negedge clk);
        check("rst_cursor", int'(cursor), 80);
        check("rst_cyc", int'(cyc), 0);
        check("rst_stb", int'(stb), 0);
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_adr", int'(adr), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        seen = 0;
        repeat (6) begin @(negedge clk); if (cyc) seen++; end
        check("idle_no_bus", seen, 0);

        do_code(8'h41);
        check("cursor_after_A", int'(cursor), 81);
        check("mem80_A", int'(mem[80]), 8'h41);
        do_code(8'h42);
        check("cursor_after_B", int'(cursor), 82);
        check("mem81_B", int'(mem[81]), 8'h42);
        do_code(8'h43); do_code(8'h44); do_code(8'h45);
        check("cursor_85", int'(cursor), 85);

        // Control codes: no bus traffic, cursor visible right after accept
        expect_code(8'h0D); send(8'h0D);
        check("cr_ready", int'(ready), 1);
        check("cr_cursor", int'(cursor), 80);
        expect_code(8'h0A); send(8'h0A);
        check("lf_cursor", int'(cursor), 160);
        expect_code(8'h08); send(8'h08);
        check("bs_col0_cursor", int'(cursor), 160);
        do_code(8'h78);
        check("cursor_161", int'(cursor), 161);
        expect_code(8'h08); send(8'h08);
        check("bs_cursor", int'(cursor), 160);
        repeat (4) @(negedge clk);
        check("ctrl_no_bus", exp_q.size(), 0);

        // Fill row 2 to col 79, then drop to the last row
        for (int i = 0; i < 79; i++) do_code(8'(8'h30 + (i % 40)));
        check("cursor_239", int'(cursor), 239);
        for (int i = 0; i < 22; i++) begin expect_code(8'h0A); send(8'h0A); end
        @(negedge clk);
        check("cursor_1999", int'(cursor), 1999);

        // Char at last position: write, then scroll
        do_code(8'h5A);
        check("scroll_cursor", int'(cursor), 1920);
        check("scroll_moved_Z", int'(mem[1919]), 8'h5A);
        check("scroll_fill", int'(mem[1920]), 8'h20);
        cmp_region("scroll_row0", 0, 80);
        cmp_region("scroll_text", 80, 1920);
        cmp_region("scroll_last", 1920, 2000);

        // Form feed
        do_code(8'h0C);
        check("ff_cursor", int'(cursor), 80);
        check("ff_mem80", int'(mem[80]), 8'h20);
        check("ff_mem1999", int'(mem[1999]), 8'h20);
        cmp_region("ff_row0", 0, 80);
        cmp_region("ff_text", 80, 2000);

        // Wrap at col 79 without scroll
        for (int i = 0; i < 80; i++) do_code(8'(8'h61 + (i % 26)));
        check("wrap_cursor", int'(cursor), 160);
        check("wrap_mem159", int'(mem[159]), 8'h61 + (79 % 26));

        // Reset in the middle of a scroll read
        for (int i = 0; i < 22; i++) begin expect_code(8'h0A); send(8'h0A); end
        @(negedge clk);
        check("cursor_1920", int'(cursor), 1920);
        mon_en = 1'b0;
        send(8'h0A);
        n = 0;
        while (!(cyc && stb && !we) && n < 200) begin @(negedge clk); n++; end
        check("scr_rd_seen", int'(cyc && stb && !we), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_cyc", int'(cyc), 0);
        check("rst_mid_stb", int'(stb), 0);
        check("rst_mid_cursor", int'(cursor), 80);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_ready", int'(ready), 1);
        check("post_rst_cyc", int'(cyc), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
